// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the multicycle RV32I control FSM
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ADDI-shaped fields make the ALU return a plain sum
    localparam logic [6:0] FORCE_ADD_OPCODE = 7'b0010011;
    localparam logic [2:0] FORCE_ADD_FUNCT3 = 3'b000;
    localparam logic [6:0] FORCE_ADD_FUNCT7 = 7'b0000000;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    function automatic logic alu_funct3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - opcode/funct3 legality check and next state after DECODE
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output state_t     next_state
);

    always_comb begin
        next_state = S_TRAP;
        case (opcode)
            OP_LOAD, OP_STORE: if (funct3 == 3'b010) next_state = S_MEMADR;
            OP_R:              if (alu_funct3_ok(funct3)) next_state = S_EXECR;
            OP_I:              if (alu_funct3_ok(funct3)) next_state = S_EXECI;
            OP_BRANCH:         if (funct3 == 3'b000) next_state = S_BEQ;
            OP_JAL:            next_state = S_JAL;
            default:           next_state = S_TRAP;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM sequencing ALU, regfile, PC/IR and memory port
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [6:0]       alu_opcode,
    output logic [2:0]       alu_funct3,
    output logic [6:0]       alu_funct7,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_o
);

    localparam int WCW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    state_t         state, next_state, dec_next;
    logic [WCW-1:0] wait_cnt;
    logic           req, we, irw, pcw, rw;
    logic           waiting, timeout, retire;
    logic           unused_bits;

    assign unused_bits = ^{instr[24:15], instr[11:7]};

    ctrl_decode u_decode (
        .opcode     (instr[6:0]),
        .funct3     (instr[14:12]),
        .next_state (dec_next)
    );

    assign waiting = req && !mem_ready;
    // Trap on the WAIT_LIMIT-th consecutive wait cycle so no handshake can follow
    assign timeout = (WAIT_LIMIT != 0) && waiting && (wait_cnt == WCW'(WAIT_LIMIT - 1));
    assign retire  = (next_state == S_FETCH) && (state != S_FETCH);

    always_comb begin
        next_state = state;
        req        = 1'b0;
        we         = 1'b0;
        irw        = 1'b0;
        pcw        = 1'b0;
        rw         = 1'b0;
        adr_src    = ADR_PC;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_opcode = FORCE_ADD_OPCODE;
        alu_funct3 = FORCE_ADD_FUNCT3;
        alu_funct7 = FORCE_ADD_FUNCT7;
        case (state)
            S_FETCH: begin
                req        = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (mem_ready) begin
                    irw        = 1'b1;
                    pcw        = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_IMM;
                next_state = dec_next;
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                next_state = (instr[6:0] == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                req     = 1'b1;
                adr_src = ADR_ALUOUT;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                rw         = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                req     = 1'b1;
                we      = 1'b1;
                adr_src = ADR_ALUOUT;
                if (mem_ready) next_state = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_opcode = instr[6:0];
                alu_funct3 = instr[14:12];
                alu_funct7 = instr[31:25];
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_opcode = instr[6:0];
                alu_funct3 = instr[14:12];
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                rw         = 1'b1;
                next_state = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_opcode = instr[6:0];
                alu_funct3 = instr[14:12];
                alu_funct7 = instr[31:25];
                pcw        = zero;
                next_state = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pcw        = 1'b1;
                next_state = S_ALUWB;
            end
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_TRAP;
        endcase
        if (timeout) next_state = S_TRAP;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            state <= next_state;
            if (waiting) wait_cnt <= wait_cnt + 1'b1;
            else         wait_cnt <= '0;
            if (retire) instret <= instret + 1'b1;
        end
    end

    assign mem_req   = req & rst_n;
    assign mem_we    = we  & rst_n;
    assign ir_write  = irw & rst_n;
    assign pc_write  = pcw & rst_n;
    assign reg_write = rw  & rst_n;
    assign illegal   = (state == S_TRAP);
    assign state_o   = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int WL = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   instr = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0]    result_src, alu_src_a, alu_src_b;
    logic [6:0]    alu_opcode, alu_funct7;
    logic [2:0]    alu_funct3;
    logic [CW-1:0] instret;
    logic [3:0]    state_o;

    always #5 clk = ~clk;

    multicycle_ctrl #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_opcode (alu_opcode),
        .alu_funct3 (alu_funct3),
        .alu_funct7 (alu_funct7),
        .illegal    (illegal),
        .instret    (instret),
        .state_o    (state_o)
    );

    int tests  = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [29:0] w;
        logic        rdy;
        logic        z;
    } rec_t;

    rec_t q[$];
    int   model_cnt = 0;

    localparam logic [16:0] FADD = {7'b0010011, 3'b000, 7'b0000000};
    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_JAL = 5;

    logic [29:0] obs;
    assign obs = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                  result_src, alu_src_a, alu_src_b, alu_opcode, alu_funct3, alu_funct7, illegal};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // en = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write}
    function automatic logic [29:0] mk(input logic [5:0] en, input logic [1:0] res,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [16:0] alu, input logic ill);
        return {en, res, a, b, alu, ill};
    endfunction

    task automatic push(input string tag, input logic [29:0] w, input logic rdy, input logic z);
        rec_t r;
        r.tag = tag; r.w = w; r.rdy = rdy; r.z = z;
        q.push_back(r);
    endtask

    function automatic logic [2:0] alu_f3();
        case ($urandom_range(0, 3))
            0:       return 3'b000;
            1:       return 3'b111;
            2:       return 3'b110;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [31:0] gen_instr(input int cls);
        logic [31:0] r;
        logic [2:0]  f3;
        r = $urandom;
        case (cls)
            C_R: begin
                f3 = alu_f3();
                r[31:25] = (f3 == 3'b000 && rb()) ? 7'b0100000 : 7'b0000000;
                r[14:12] = f3;
                r[6:0]   = 7'b0110011;
            end
            C_I:     begin r[14:12] = alu_f3(); r[6:0] = 7'b0010011; end
            C_LW:    begin r[14:12] = 3'b010;   r[6:0] = 7'b0000011; end
            C_SW:    begin r[14:12] = 3'b010;   r[6:0] = 7'b0100011; end
            C_BEQ:   begin r[14:12] = 3'b000;   r[6:0] = 7'b1100011; end
            default: r[6:0] = 7'b1101111;
        endcase
        return r;
    endfunction

    task automatic add_fetch(input int waits);
        for (int i = 0; i < waits; i++)
            push("fetch_wait", mk(6'b100000, 2'b10, 2'b00, 2'b10, FADD, 1'b0), 1'b0, rb());
        push("fetch", mk(6'b100110, 2'b10, 2'b00, 2'b10, FADD, 1'b0), 1'b1, rb());
        push("decode", mk(6'b000000, 2'b00, 2'b01, 2'b01, FADD, 1'b0), rb(), rb());
    endtask

    task automatic add_body(input int cls, input logic [31:0] iv, input int mw, input logic zv);
        logic [16:0] pt;
        pt = {iv[6:0], iv[14:12], iv[31:25]};
        case (cls)
            C_R: begin
                push("execr", mk(6'b000000, 2'b00, 2'b10, 2'b00, pt, 1'b0), rb(), rb());
                push("aluwb", mk(6'b000001, 2'b00, 2'b00, 2'b00, FADD, 1'b0), rb(), rb());
            end
            C_I: begin
                push("execi", mk(6'b000000, 2'b00, 2'b10, 2'b01, {pt[16:7], 7'b0}, 1'b0), rb(), rb());
                push("aluwb", mk(6'b000001, 2'b00, 2'b00, 2'b00, FADD, 1'b0), rb(), rb());
            end
            C_LW, C_SW: begin
                logic [5:0] en;
                en = (cls == C_LW) ? 6'b101000 : 6'b111000;
                push("memadr", mk(6'b000000, 2'b00, 2'b10, 2'b01, FADD, 1'b0), rb(), rb());
                for (int i = 0; i < mw; i++)
                    push("mem_wait", mk(en, 2'b00, 2'b00, 2'b00, FADD, 1'b0), 1'b0, rb());
                push("mem_done", mk(en, 2'b00, 2'b00, 2'b00, FADD, 1'b0), 1'b1, rb());
                if (cls == C_LW)
                    push("memwb", mk(6'b000001, 2'b01, 2'b00, 2'b00, FADD, 1'b0), rb(), rb());
            end
            C_BEQ:
                push("beq", mk({4'b0000, zv, 1'b0}, 2'b00, 2'b10, 2'b00, pt, 1'b0), rb(), zv);
            default: begin
                push("jal", mk(6'b000010, 2'b00, 2'b01, 2'b10, FADD, 1'b0), rb(), rb());
                push("jal_wb", mk(6'b000001, 2'b00, 2'b00, 2'b00, FADD, 1'b0), rb(), rb());
            end
        endcase
    endtask

    task automatic run_q();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            mem_ready = r.rdy;
            zero      = r.z;
            #1;
            check(r.tag, 32'(obs), 32'(r.w));
            @(negedge clk);
        end
    endtask

    task automatic run_instr_v(input int cls, input logic [31:0] iv, input int fw, input int mw,
                               input logic zv);
        instr = iv;
        add_fetch(fw);
        add_body(cls, iv, mw, zv);
        run_q();
        model_cnt = (model_cnt + 1) % (1 << CW);
        check("instret", 32'(instret), 32'(model_cnt));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = rb();
        #1;
        check("rst_mask", {27'b0, mem_req, mem_we, ir_write, pc_write, reg_write}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        model_cnt = 0;
        check("rst_instret", 32'(instret), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
    endtask

    task automatic run_trap(input logic [31:0] iv, input int n);
        instr = iv;
        add_fetch(0);
        for (int i = 0; i < n; i++)
            push("trap", mk(6'b000000, 2'b00, 2'b00, 2'b00, FADD, 1'b1), rb(), rb());
        run_q();
        check("trap_instret", 32'(instret), 32'(model_cnt));
        do_reset();
    endtask

    initial begin
        int cls;
        repeat (2) @(negedge clk);
        do_reset();

        run_instr_v(C_R, {7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 0, 0, 1'b0);
        run_instr_v(C_LW, {12'h010, 5'd1, 3'b010, 5'd4, 7'b0000011}, 0, 3, 1'b0);
        run_instr_v(C_BEQ, gen_instr(C_BEQ), 0, 0, 1'b1);
        run_instr_v(C_BEQ, gen_instr(C_BEQ), 0, 0, 1'b0);
        run_instr_v(C_JAL, gen_instr(C_JAL), 0, 0, 1'b0);
        run_instr_v(C_SW, gen_instr(C_SW), WL - 1, WL - 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 5);
            run_instr_v(cls, gen_instr(cls), $urandom_range(0, WL - 1), $urandom_range(0, WL - 1), rb());
        end

        run_trap({25'h0ABCDE, 7'b0110111}, 20);
        run_trap({17'h0, 3'b001, 5'd1, 7'b0110011}, 3);
        run_trap({17'h0, 3'b001, 5'd0, 7'b1100011}, 3);
        run_trap({17'h0, 3'b000, 5'd2, 7'b0000011}, 3);

        run_instr_v(C_I, gen_instr(C_I), 0, 0, 1'b0);
        instr = gen_instr(C_SW);
        add_fetch(1);
        push("memadr", mk(6'b000000, 2'b00, 2'b10, 2'b01, FADD, 1'b0), rb(), rb());
        for (int i = 0; i < WL; i++)
            push("memwr_hold", mk(6'b111000, 2'b00, 2'b00, 2'b00, FADD, 1'b0), 1'b0, rb());
        for (int i = 0; i < 3; i++)
            push("timeout_trap", mk(6'b000000, 2'b00, 2'b00, 2'b00, FADD, 1'b1), rb(), rb());
        run_q();
        check("timeout_instret", 32'(instret), 32'(model_cnt));
        do_reset();

        run_instr_v(C_R, gen_instr(C_R), 0, 0, 1'b0);
        instr = gen_instr(C_LW);
        add_fetch(0);
        push("memadr", mk(6'b000000, 2'b00, 2'b10, 2'b01, FADD, 1'b0), rb(), rb());
        push("memrd_wait", mk(6'b101000, 2'b00, 2'b00, 2'b00, FADD, 1'b0), 1'b0, rb());
        push("memrd_wait", mk(6'b101000, 2'b00, 2'b00, 2'b00, FADD, 1'b0), 1'b0, rb());
        run_q();
        do_reset();
        run_instr_v(C_I, gen_instr(C_I), 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the shared single ALU, register file, PC/IR registers and unified memory port of the multicycle RV32I core.
- Supported subset: ADD/SUB/AND/OR/SLT, ADDI/ANDI/ORI/SLTI, LW, SW, BEQ, JAL.
- Drives the ALU's opcode/funct3/funct7 inputs. In address and PC arithmetic states it forces ADDI fields so the ALU returns Sum.
- Also provides a bounded-wait memory handshake, a sticky illegal-instruction trap and a retired-instruction counter.

Parameters:
- WAIT_LIMIT, 0: maximum mem_req cycles without mem_ready; 0 disables the timeout.
- CNT_W, 32: width of instret.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- instr  in  32  IR contents (opcode [6:0], funct3 [14:12], funct7 [31:25])
- zero  in  1  ALU Zero flag, same cycle
- mem_ready  in  1  memory completes the current request
- mem_req  out  1  memory request valid
- mem_we  out  1  write request (qualifies mem_req)
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  load PC from result mux
- reg_write  out  1  register-file write enable
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 reg
- alu_src_b  out  2  00 = rs2 reg, 01 = ImmExt, 10 = const 4
- alu_opcode  out  7  to ALU opcode
- alu_funct3  out  3  to ALU funct3
- alu_funct7  out  7  to ALU funct7
- illegal  out  1  sticky trap flag
- instret  out  CNT_W  retired-instruction count
- state_o  out  4  current state (debug)

Behaviour:
- Reset: synchronous and active-low; sampled on the clk rising edge.
  - State goes to FETCH; instret, illegal and the wait counter clear to 0.
  - While rst_n = 0, mem_req, mem_we, ir_write, pc_write and reg_write are masked to 0 combinationally.
  - Reset mid-transaction abandons it with no write.
- Output defaults (any field a state does not list):
  - All enables 0; result_src, alu_src_a, alu_src_b and adr_src all 0.
  - ALU fields = FORCE_ADD (0010011 / 000 / 0000000).
- States and transitions:
  - FETCH: mem_req = 1, adr_src = 0, src_a = PC, src_b = 4, result_src = 10. Hold until mem_ready. On the ready cycle: ir_write = 1, pc_write = 1, go to DECODE.
  - DECODE: src_a = OldPC, src_b = Imm; ALUOut receives the branch/jump target. Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode, or unsupported funct3 -> TRAP. Supported funct3: R/I 000/111/110/010; LW/SW 010; BEQ 000.
  - MEMADR: src_a = rs1, src_b = Imm, FORCE_ADD. FORCE_ADD is mandatory here: LW's native ALU encoding returns SrcB. Next: LW -> MEMREAD, SW -> MEMWRITE.
  - MEMREAD: mem_req = 1, adr_src = 1; hold until mem_ready, then go to MEMWB.
  - MEMWB: result_src = 01, reg_write = 1 -> FETCH.
  - MEMWRITE: mem_req = 1, mem_we = 1, adr_src = 1; hold until mem_ready, then go to FETCH.
  - EXECR: src_a = rs1, src_b = rs2, ALU fields = instr passthrough -> ALUWB.
  - EXECI: src_a = rs1, src_b = Imm, passthrough, except alu_funct7 forced 0 -> ALUWB.
  - ALUWB: result_src = 00, reg_write = 1 -> FETCH.
  - BEQ: src_a = rs1, src_b = rs2, passthrough (ALU produces Sub). result_src = 00, pc_write = zero (combinational) -> FETCH.
  - JAL: src_a = OldPC, src_b = 4, result_src = 00, pc_write = 1 -> ALUWB (rd <- OldPC + 4).
  - TRAP: illegal = 1, all enables 0; terminal until reset.
- Latency (cycles, zero-wait memory):
  - FETCH and DECODE: 1 each.
  - Total per instruction: R/I 4, LW 5, SW 4, BEQ 3, JAL 4.
  - Each memory wait cycle adds 1.
- Handshake rules:
  - mem_req, mem_we and adr_src stay stable until the cycle mem_ready = 1.
  - mem_ready is ignored while mem_req = 0.
- Timeout:
  - The wait counter increments on each mem_req && !mem_ready cycle and clears on handshake.
  - If WAIT_LIMIT != 0 and the counter reaches WAIT_LIMIT, go to TRAP; no write occurs.
- instret:
  - +1 on each transition into FETCH from MEMWB, MEMWRITE(ready), ALUWB or BEQ.
  - The JAL -> ALUWB path counts once.
  - Wraps modulo 2^CNT_W.

Decomposition:
- Package ctrl_pkg holds:
  - state enum (4-bit);
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL;
  - FORCE_ADD field constants;
  - result/src mux encodings.
- Optional sub-module ctrl_decode: combinational opcode/funct3 legality check plus next-state after DECODE.
- The FSM, wait counter and instret live in multicycle_ctrl.

Test Plan:
- ADD, zero-wait memory -> FETCH, DECODE, EXECR, ALUWB; alu_opcode = 0110011 in EXECR; reg_write = 1 only in ALUWB; instret 0 -> 1 after 4 cycles.
- LW with mem_ready delayed 3 cycles in MEMREAD -> MEMADR shows alu_opcode = 0010011, funct3 = 000; mem_req/adr_src = 1 held 4 cycles; 8 cycles total.
- BEQ with zero = 1, then zero = 0 -> pc_write = 1 in BEQ for the first only; result_src = 00 both times.
- JAL -> pc_write = 1 in JAL; reg_write = 1 with result_src = 00 in the following ALUWB; instret +1 exactly.
- instr opcode 0110111 (LUI) -> TRAP after DECODE; illegal = 1 and no enables for 20 cycles; rst_n low one cycle -> FETCH, illegal = 0.
- WAIT_LIMIT = 5, mem_ready held 0 in MEMWRITE -> TRAP after 5 wait cycles with mem_we never handshaken. Separately, rst_n low during MEMREAD -> all enables 0 that cycle, then FETCH; instret = 0.
